// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and widths for the LED frame scheduler.
package led_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} led_sched_state_t;

  localparam int LED_FRAME_W     = 128;
  localparam int LED_FRAME_CNT_W = 16;

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Handshake bundle between the two frame sources, the scheduler and the
// LED serial sender. master = source/sender side, slave = scheduler.
interface led_sched_if
  import led_pkg::*;
#(
  parameter int DATA_W = LED_FRAME_W
);

  logic                       req0_valid;
  logic [DATA_W-1:0]          req0_data;
  logic                       req0_ready;
  logic                       req1_valid;
  logic [DATA_W-1:0]          req1_data;
  logic                       req1_ready;
  logic                       send_en;
  logic [DATA_W-1:0]          send_data;
  logic                       busy;
  logic [LED_FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, send_en, send_data, busy, frame_cnt
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, send_en, send_data, busy, frame_cnt
  );

endinterface

// File: rtl/led_frame_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. rr_last holds the index granted at the most
// recent accepted handshake; on contention the other requester wins.
module led_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       rr_last
);

  // Grant selection: a lone requester always wins, contention alternates.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // rr_last moves only on a real handshake; reset favours requester 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant[1];
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: accepts frames from two round-robin requesters and
// emits one send_en pulse per frame, spaced at least FRAME_CYCLES apart.
// Optional macro LED_SCHED_REFRESH_EN enables resending the last frame after
// REFRESH_CYCLES idle cycles.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int DATA_W         = LED_FRAME_W,
  parameter int FRAME_CYCLES   = 1024,
  parameter int REFRESH_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  led_sched_if.slave  bus
);

  // SEND and the final GAP cycle account for 2 of the FRAME_CYCLES, and the
  // next handshake cycle is the last, so the gap counter starts at F-3.
  localparam logic [15:0] GAP_LOAD = 16'(FRAME_CYCLES - 3);

  if (FRAME_CYCLES < 3 || FRAME_CYCLES > 65535) begin : g_bad_frame_cycles
    $error("led_frame_scheduler: FRAME_CYCLES must be in 3..65535");
  end
  if (REFRESH_CYCLES < 1 || REFRESH_CYCLES > 65535) begin : g_bad_refresh_cycles
    $error("led_frame_scheduler: REFRESH_CYCLES must be in 1..65535");
  end

  led_sched_state_t           state_reg, state_next;
  logic [DATA_W-1:0]          send_data_reg;
  logic [LED_FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [15:0]                gap_cnt_reg;

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [1:0]        hs;
  logic              any_hs;
  logic              rr_last;
  logic              refresh_go;
  logic [DATA_W-1:0] hs_data;

  assign valid = {bus.req1_valid, bus.req0_valid};

  led_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .accept  (any_hs),
    .grant   (grant),
    .rr_last (rr_last)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign ready[gi] = (state_reg == S_IDLE) && grant[gi] && !rst;
    assign hs[gi]    = ready[gi] && valid[gi];
  end

  assign any_hs  = |hs;
  assign hs_data = hs[1] ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.send_en    = (state_reg == S_SEND) && !rst;
  assign bus.send_data  = send_data_reg;
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.frame_cnt  = frame_cnt_reg;

`ifdef LED_SCHED_REFRESH_EN
  localparam logic [15:0] REFRESH_LIM = 16'(REFRESH_CYCLES);

  logic [15:0] idle_cnt_reg;
  logic        have_frame_reg;

  assign refresh_go = (state_reg == S_IDLE) && !any_hs && have_frame_reg &&
                      (idle_cnt_reg == REFRESH_LIM) && !rst;

  // Idle timer saturates at the refresh limit; any non-IDLE state clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_reg   <= '0;
      have_frame_reg <= 1'b0;
    end else begin
      if (state_reg == S_SEND) begin
        have_frame_reg <= 1'b1;
      end
      if (state_reg != S_IDLE) begin
        idle_cnt_reg <= '0;
      end else if (!any_hs && idle_cnt_reg != REFRESH_LIM) begin
        idle_cnt_reg <= idle_cnt_reg + 16'd1;
      end
    end
  end
`else
  assign refresh_go = 1'b0;
`endif

  // Next-state logic: handshake (or refresh) -> SEND -> GAP -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_hs || refresh_go) state_next = S_SEND;
      S_SEND:  state_next = S_GAP;
      S_GAP:   if (gap_cnt_reg == 16'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, frame latch, frame counter and inter-frame gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      send_data_reg <= '0;
      frame_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (any_hs) begin
        send_data_reg <= hs_data;
      end
      if (state_reg == S_SEND) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
        gap_cnt_reg   <= GAP_LOAD;
      end else if (state_reg == S_GAP && gap_cnt_reg != 16'd0) begin
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler (FRAME_CYCLES=8, REFRESH_CYCLES=20).
// Stimulus pushes the expected frame, pulse cycle and frame count; a monitor
// pops on every send_en pulse and compares.
module tb_led_frame_scheduler;
  import led_pkg::*;

  localparam int FC = 8;
  localparam int RC = 20;

  typedef struct {
    logic [127:0] data;
    int           cyc;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [15:0] exp_frames = 16'd0;
  logic        cnt_pending = 1'b0;
  logic [15:0] cnt_exp = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_sched_if #(.DATA_W(LED_FRAME_W)) bus ();

  led_frame_scheduler #(
    .DATA_W         (LED_FRAME_W),
    .FRAME_CYCLES   (FC),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input logic [127:0] d, input int c);
    exp_t it;
    exp_frames = exp_frames + 16'd1;
    it.data = d;
    it.cyc  = c;
    it.cnt  = exp_frames;
    sb.push_back(it);
  endtask

  // Bounded wait for a handshake; returns requester index and cycle.
  task automatic wait_hs(input string name, output int idx, output int hcyc);
    idx = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req0_valid) begin idx = 0; break; end
      if (bus.req1_ready && bus.req1_valid) begin idx = 1; break; end
    end
    hcyc = cyc;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no handshake within 64 cycles", name);
    end
  endtask

  // Monitor: pops one expected frame per send_en pulse.
  always @(negedge clk) begin
    exp_t it;
    if (cnt_pending) begin
      cnt_pending = 1'b0;
      checks++;
      if (bus.frame_cnt !== cnt_exp) begin
        errors++;
        $display("FAIL frame_cnt: got %0h expected %0h (cycle %0d)", bus.frame_cnt, cnt_exp, cyc);
      end
    end
    if (bus.req0_ready && bus.req1_ready) begin
      checks++;
      errors++;
      $display("FAIL both_ready: got req0_ready=1 req1_ready=1 expected at most one (cycle %0d)", cyc);
    end
    if (bus.send_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send: got send_en=1 data %0h expected no pulse (cycle %0d)", bus.send_data, cyc);
      end else begin
        it = sb.pop_front();
        if (bus.send_data !== it.data || cyc != it.cyc) begin
          errors++;
          $display("FAIL send: got data %0h at cycle %0d expected %0h at cycle %0d",
                   bus.send_data, cyc, it.data, it.cyc);
        end else begin
          $display("ok   send: data %0h at cycle %0d", bus.send_data, cyc);
        end
        cnt_pending = 1'b1;
        cnt_exp     = it.cnt;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, hcyc, t0, prev, pulses;
    logic [127:0] d0, d1;

    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;

    // Reset; req0 valid during reset must not be accepted.
    rst = 1'b1;
    tick(); tick();
    bus.req0_valid = 1'b1; bus.req0_data = 128'hA5;
    @(negedge clk);
    chk("rst_send_en",   bus.send_en, 1'b0);
    chk("rst_send_data", bus.send_data, 128'h0);
    chk("rst_busy",      bus.busy, 1'b0);
    chk("rst_frame_cnt", bus.frame_cnt, 16'h0);
    chk("rst_ready0",    bus.req0_ready, 1'b0);
    tick();
    rst = 1'b0;

    // Single frame from req0, busy for FC-1 cycles after the handshake.
    wait_hs("hs_a5", idx, hcyc);
    chk("hs_a5_idx", idx, 0);
    push(128'hA5, hcyc + 1);
    tick();
    bus.req0_valid = 1'b0;
    for (int k = 1; k <= FC; k++) begin
      @(negedge clk);
      chk("busy_window", bus.busy, (k <= FC - 1));
    end

    // req1 asserts during GAP: not ready until IDLE, send_data held.
    tick();
    bus.req0_valid = 1'b1; bus.req0_data = 128'h11;
    wait_hs("hs_11", idx, t0);
    push(128'h11, t0 + 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b1; bus.req1_data = 128'h22;
    for (int k = 2; k <= FC - 1; k++) begin
      @(negedge clk);
      chk("gap_ready1", bus.req1_ready, 1'b0);
      chk("gap_data",   bus.send_data, 128'h11);
    end
    wait_hs("hs_22", idx, hcyc);
    chk("hs_22_idx", idx, 1);
    chk("hs_22_cycle", hcyc, t0 + FC);
    push(128'h22, hcyc + 1);
    tick();
    bus.req1_valid = 1'b0;

    // Both valid continuously: alternate 0,1,0,1 spaced FC apart.
    d0 = 128'h1000; d1 = 128'h2000;
    bus.req0_valid = 1'b1; bus.req0_data = d0;
    bus.req1_valid = 1'b1; bus.req1_data = d1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_hs("hs_rr", idx, hcyc);
      chk("rr_idx", idx, k % 2);
      if (k > 0) chk("rr_spacing", hcyc - prev, FC);
      prev = hcyc;
      push((idx == 0) ? d0 : d1, hcyc + 1);
      tick();
      if (idx == 0) begin d0 = d0 + 128'h1; bus.req0_data = d0; end
      else          begin d1 = d1 + 128'h1; bus.req1_data = d1; end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Reset during SEND: pulse dropped, counters cleared, req0 wins next.
    bus.req0_valid = 1'b1; bus.req0_data = 128'h77;
    wait_hs("hs_77", idx, hcyc);
    tick();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_send_drop", bus.send_en, 1'b0);
    tick();
    rst = 1'b0;
    exp_frames = 16'd0;
    @(negedge clk);
    chk("rst2_send_data", bus.send_data, 128'h0);
    chk("rst2_frame_cnt", bus.frame_cnt, 16'h0);
    chk("rst2_busy",      bus.busy, 1'b0);
    tick();
    bus.req0_valid = 1'b1; bus.req0_data = 128'hB0;
    bus.req1_valid = 1'b1; bus.req1_data = 128'hB1;
    wait_hs("hs_b0", idx, hcyc);
    chk("post_rst_idx", idx, 0);
    push(128'hB0, hcyc + 1);
    tick();
    bus.req0_valid = 1'b0;
    wait_hs("hs_b1", idx, hcyc);
    chk("post_rst_idx2", idx, 1);
    push(128'hB1, hcyc + 1);
    tick();
    bus.req1_valid = 1'b0;

    // frame_cnt wrap: preload 0xFFFF while idle, next pulse wraps to 0.
    repeat (FC) tick();
    force dut.frame_cnt_reg = 16'hFFFF;
    tick();
    release dut.frame_cnt_reg;
    exp_frames = 16'hFFFF;
    bus.req0_valid = 1'b1; bus.req0_data = 128'hC0;
    wait_hs("hs_c0", idx, hcyc);
    push(128'hC0, hcyc + 1);
    tick();
    bus.req0_valid = 1'b0;
    repeat (FC) tick();

    // Last frame 0x3C then silence.
    bus.req0_valid = 1'b1; bus.req0_data = 128'h3C;
    wait_hs("hs_3c", idx, t0);
    push(128'h3C, t0 + 1);
    tick();
    bus.req0_valid = 1'b0;
`ifdef LED_SCHED_REFRESH_EN
    // Resend after RC idle cycles, second resend cycle taken by a request.
    push(128'h3C, t0 + FC + RC + 1);
    while (cyc != t0 + 2 * (FC - 1 + RC) + 2) tick();
    bus.req1_valid = 1'b1; bus.req1_data = 128'h5A;
    wait_hs("hs_5a", idx, hcyc);
    chk("refresh_hs_idx", idx, 1);
    chk("refresh_hs_cycle", hcyc, t0 + 2 * (FC - 1 + RC) + 2);
    push(128'h5A, hcyc + 1);
    tick();
    bus.req1_valid = 1'b0;
    repeat (FC + 4) tick();
`else
    pulses = 0;
    for (int k = 0; k < 3 * RC; k++) begin
      @(negedge clk);
      if (bus.send_en === 1'b1) pulses++;
    end
    chk("no_resend_pulses", pulses, 1);
`endif

    repeat (4) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences 128-bit LED frames into the LED serial sender (enable/data_in interface) at a guaranteed minimum frame spacing.
- Arbitrates round-robin between two frame sources: requester 0 (test pattern generator) and requester 1 (host/frame buffer).
- Sits in the 150 MHz LED clock domain, between the frame sources and the sender.

Parameters:
- DATA_W, 128, frame word width; matches sender data_in.
- FRAME_CYCLES, 1024, minimum clk cycles between consecutive send_en pulses; legal range 3..65535.
- REFRESH_CYCLES, 65535, idle cycles before the last frame is resent (used only with LED_SCHED_REFRESH_EN); legal range 1..65535.

Ports:
- clk  in  1  LED-domain clock (150 MHz).
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 frame available.
- req0_data  in  DATA_W  requester 0 frame.
- req0_ready  out  1  requester 0 frame accepted this cycle.
- req1_valid  in  1  requester 1 frame available.
- req1_data  in  DATA_W  requester 1 frame.
- req1_ready  out  1  requester 1 frame accepted this cycle.
- send_en  out  1  one-cycle pulse to the sender's enable input.
- send_data  out  DATA_W  frame to the sender's data_in; held stable between pulses.
- busy  out  1  high whenever state is not IDLE.
- frame_cnt  out  16  count of send_en pulses since reset.

Behaviour:
- Reset is synchronous, active-high: clk rising edge with rst=1 → state IDLE, send_en=0, send_data=0, busy=0, frame_cnt=0, rr_last=1 (so requester 0 wins first), gap/idle counters=0, have_frame=0.
- Readies are combinational: reqX_ready = (state==IDLE) && grantX && !rst. A handshake is valid&&ready.
- Grant rules:
  - Only one requester valid → that requester is granted.
  - Both valid → grant the requester other than rr_last.
  - rr_last updates to the granted index on each handshake only.
- Three-state machine:
  - IDLE: on a handshake, latch reqX_data into send_data and go to SEND.
  - SEND: send_en=1 for exactly this one cycle; frame_cnt += 1 (wraps 0xFFFF→0); gap counter loads FRAME_CYCLES-3; next state GAP.
  - GAP: counter decrements each cycle; when it reaches 0, go to IDLE. The cycle before IDLE counts as the final GAP cycle.
- Timing:
  - Handshake at cycle t → send_en at t+1.
  - Earliest next handshake at t+FRAME_CYCLES.
  - So send_en pulses are exactly FRAME_CYCLES apart under continuous requests.
- send_data changes only on a handshake (or on refresh reload). It is never modified in SEND or GAP.
- valid deasserting without a handshake is legal: no grant, and rr_last is unchanged.
- Data is sampled only at the handshake cycle; a requester may change data freely otherwise.
- have_frame sets on the first SEND after reset.
- rst asserted in any state (including SEND) → the next edge applies reset values; a pending send_en pulse is dropped and no partial frame is signalled.

Optional Feature:
- LED_SCHED_REFRESH_EN defined:
  - An idle counter increments every IDLE cycle without a handshake, saturating at REFRESH_CYCLES. It clears on leaving IDLE.
  - When it equals REFRESH_CYCLES and have_frame=1, go to SEND with send_data unchanged (a resend). rr_last is unchanged and no ready is asserted.
  - A handshake in the same cycle takes priority over the refresh.
  - Until the first frame after reset, no refresh occurs.
- LED_SCHED_REFRESH_EN not defined: no idle counter and no resends; the block is purely request-driven. REFRESH_CYCLES is ignored.

Decomposition:
- Package led_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} led_sched_state_t;
  - localparam LED_FRAME_W = 128;
  - localparam LED_FRAME_CNT_W = 16.
- One natural sub-module: led_rr_arb2, the 2-way round-robin arbiter (valid[1:0], rr_last → grant[1:0]), purely combinational plus the rr_last register. The FSM and counters stay in the top module.

Test Plan (FRAME_CYCLES=8, REFRESH_CYCLES=20 unless noted):
- Reset then req0_valid=1, data=128'hA5 at cycle 5 → req0_ready=1 at cycle 5; send_en=1 with send_data=128'hA5 at cycle 6; busy high cycles 6–12; frame_cnt=1.
- req0 and req1 held valid continuously → grants alternate 0,1,0,1; send_en at cycles t+1, t+9, t+17, t+25; never two requesters ready in one cycle.
- req1 asserts valid during GAP → req1_ready stays 0 until the first IDLE cycle; send_data unchanged through GAP.
- rst pulsed the cycle after a handshake (in SEND) → send_en=0, frame_cnt=0, send_data=0 next cycle; a subsequent both-valid request grants req0 first.
- frame_cnt forced near wrap (65535 frames, or a bench-reduced FRAME_CYCLES=3 run) → the next send_en wraps frame_cnt to 0.
- With LED_SCHED_REFRESH_EN: one frame 128'h3C, then no requests → resend of 128'h3C with send_en 20 IDLE cycles after GAP ends. Without the macro → no further send_en. A request arriving on the refresh cycle → its data is sent, not a resend.
